// File: rtl/hm_tx_arb_pkg.sv
// Shared types and state encodings for the TRN transmit arbiter.
package hm_tx_arb_pkg;

  localparam int unsigned TD_W  = 64;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned BUF_W = 6;

  localparam logic [1:0] HM_ARB_STATE_IDLE  = 2'd0;
  localparam logic [1:0] HM_ARB_STATE_GNT_A = 2'd1;
  localparam logic [1:0] HM_ARB_STATE_GNT_B = 2'd2;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic            cyc_n;
    logic [TD_W-1:0] td;
    logic            tsof_n;
    logic            teof_n;
    logic            trem_n;
    logic            tsrc_rdy_n;
  } trn_beat_t;

  localparam trn_beat_t TRN_BEAT_IDLE = '{
    cyc_n: 1'b1, td: '0, tsof_n: 1'b1, teof_n: 1'b1, trem_n: 1'b1, tsrc_rdy_n: 1'b1
  };

  // A beat moves only when the frame is open, the source is valid and the core is ready.
  function automatic logic beat_accepted(input trn_beat_t b, input logic dst_rdy_n);
    return ~b.cyc_n & ~b.tsrc_rdy_n & ~dst_rdy_n;
  endfunction

endpackage

// File: rtl/hm_tx_arb_wdog.sv
// Stuck-grant watchdog: counts granted cycles without an accepted beat.
module hm_tx_arb_wdog
  import hm_tx_arb_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT = 16'd4096
) (
  input  logic trn_clk,
  input  logic sys_rst,
  input  logic active,
  input  logic kick,
  output logic fire_c
);

  logic [CNT_W-1:0] cnt;

  assign fire_c = active & ~kick & (cnt == TIMEOUT - CNT_W'(1));

  always_ff @(posedge trn_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (!active || kick || fire_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hm_tx_arb.sv
// Two-port TRN transmit arbiter: whole-packet grants, round-robin on ties,
// buffer-gated, with packet/drop statistics and a stuck-grant watchdog.
module hm_tx_arb
  import hm_tx_arb_pkg::*;
#(
  parameter logic [BUF_W-1:0] MIN_BUF_AV = 6'd2,
  parameter logic [CNT_W-1:0] TIMEOUT    = 16'd4096
) (
  input  logic             trn_clk,
  input  logic             sys_rst,
  input  logic             a_cyc_n,
  input  logic [TD_W-1:0]  a_td,
  input  logic             a_tsof_n,
  input  logic             a_teof_n,
  input  logic             a_trem_n,
  input  logic             a_tsrc_rdy_n,
  output logic             a_tdst_rdy_n,
  input  logic             b_cyc_n,
  input  logic [TD_W-1:0]  b_td,
  input  logic             b_tsof_n,
  input  logic             b_teof_n,
  input  logic             b_trem_n,
  input  logic             b_tsrc_rdy_n,
  output logic             b_tdst_rdy_n,
  output logic             trn_cyc_n,
  output logic [TD_W-1:0]  trn_td,
  output logic             trn_tsof_n,
  output logic             trn_teof_n,
  output logic             trn_trem_n,
  output logic             trn_tsrc_rdy_n,
  input  logic             trn_tdst_rdy_n,
  input  logic [BUF_W-1:0] trn_tbuf_av,
  input  logic             trn_terr_drop_n,
  output logic [CNT_W-1:0] stat_pkt_a,
  output logic [CNT_W-1:0] stat_pkt_b,
  output logic [CNT_W-1:0] stat_drop,
  output logic             err_abort,
  output logic             err_timeout
);

  trn_beat_t  beat_a, beat_b, tx;
  logic [1:0] state, state_nxt;
  logic       last_grant, last_grant_nxt;
  logic       eof_seen, eof_seen_nxt;
  logic       blk_a, blk_a_nxt, blk_b, blk_b_nxt;
  logic       inc_a, inc_b, abort_c, timeout_c;
  logic       req_a, req_b, buf_ok, granted, accept, wdog_fire;

  assign beat_a = '{cyc_n: a_cyc_n, td: a_td, tsof_n: a_tsof_n, teof_n: a_teof_n,
                    trem_n: a_trem_n, tsrc_rdy_n: a_tsrc_rdy_n};
  assign beat_b = '{cyc_n: b_cyc_n, td: b_td, tsof_n: b_tsof_n, teof_n: b_teof_n,
                    trem_n: b_trem_n, tsrc_rdy_n: b_tsrc_rdy_n};

  // TX mux: the granted port drives the core, otherwise the bus idles.
  always_comb begin
    tx = TRN_BEAT_IDLE;
    case (state)
      HM_ARB_STATE_GNT_A: tx = beat_a;
      HM_ARB_STATE_GNT_B: tx = beat_b;
      default:            tx = TRN_BEAT_IDLE;
    endcase
  end

  assign trn_cyc_n      = tx.cyc_n;
  assign trn_td         = tx.td;
  assign trn_tsof_n     = tx.tsof_n;
  assign trn_teof_n     = tx.teof_n;
  assign trn_trem_n     = tx.trem_n;
  assign trn_tsrc_rdy_n = tx.tsrc_rdy_n;
  assign a_tdst_rdy_n   = (state == HM_ARB_STATE_GNT_A) ? trn_tdst_rdy_n : 1'b1;
  assign b_tdst_rdy_n   = (state == HM_ARB_STATE_GNT_B) ? trn_tdst_rdy_n : 1'b1;

  // A port that timed out stays blocked until it lets go of cyc_n.
  assign req_a   = ~a_cyc_n & ~blk_a;
  assign req_b   = ~b_cyc_n & ~blk_b;
  assign buf_ok  = (trn_tbuf_av >= MIN_BUF_AV);
  assign granted = (state != HM_ARB_STATE_IDLE);
  assign accept  = beat_accepted(tx, trn_tdst_rdy_n);

  hm_tx_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .trn_clk (trn_clk),
    .sys_rst (sys_rst),
    .active  (granted),
    .kick    (accept),
    .fire_c  (wdog_fire)
  );

  always_ff @(posedge trn_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= HM_ARB_STATE_IDLE;
      last_grant <= PORT_B;
      eof_seen   <= 1'b0;
      blk_a      <= 1'b0;
      blk_b      <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      eof_seen   <= eof_seen_nxt;
      blk_a      <= blk_a_nxt;
      blk_b      <= blk_b_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    eof_seen_nxt   = eof_seen;
    blk_a_nxt      = blk_a & ~a_cyc_n;
    blk_b_nxt      = blk_b & ~b_cyc_n;
    inc_a          = 1'b0;
    inc_b          = 1'b0;
    abort_c        = 1'b0;
    timeout_c      = 1'b0;
    case (state)
      HM_ARB_STATE_IDLE: begin
        eof_seen_nxt = 1'b0;
        if (buf_ok) begin
          if (req_a && (!req_b || last_grant == PORT_B)) begin
            state_nxt      = HM_ARB_STATE_GNT_A;
            last_grant_nxt = PORT_A;
          end else if (req_b) begin
            state_nxt      = HM_ARB_STATE_GNT_B;
            last_grant_nxt = PORT_B;
          end
        end
      end
      HM_ARB_STATE_GNT_A, HM_ARB_STATE_GNT_B: begin
        if (tx.cyc_n) begin
          state_nxt    = HM_ARB_STATE_IDLE;
          eof_seen_nxt = 1'b0;
          if (eof_seen) begin
            inc_a = (state == HM_ARB_STATE_GNT_A);
            inc_b = (state == HM_ARB_STATE_GNT_B);
          end else begin
            abort_c = 1'b1;
          end
        end else if (wdog_fire) begin
          state_nxt    = HM_ARB_STATE_IDLE;
          eof_seen_nxt = 1'b0;
          timeout_c    = 1'b1;
          if (state == HM_ARB_STATE_GNT_A) begin
            blk_a_nxt = 1'b1;
          end else begin
            blk_b_nxt = 1'b1;
          end
        end else if (accept && !tx.teof_n) begin
          eof_seen_nxt = 1'b1;
        end
      end
      default: state_nxt = HM_ARB_STATE_IDLE;
    endcase
  end

  // Statistics and error pulses.
  always_ff @(posedge trn_clk or posedge sys_rst) begin
    if (sys_rst) begin
      stat_pkt_a  <= '0;
      stat_pkt_b  <= '0;
      stat_drop   <= '0;
      err_abort   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (inc_a) stat_pkt_a <= stat_pkt_a + CNT_W'(1);
      if (inc_b) stat_pkt_b <= stat_pkt_b + CNT_W'(1);
      if (!trn_terr_drop_n) stat_drop <= stat_drop + CNT_W'(1);
      err_abort   <= abort_c;
      err_timeout <= timeout_c;
    end
  end

endmodule

// File: tb/tb_hm_tx_arb.sv
// Bench for hm_tx_arb: vector table, directed corner sequences, and a
// randomized packet-level scoreboard.
module tb_hm_tx_arb;

  logic        trn_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        a_cyc_n, a_tsof_n, a_teof_n, a_trem_n, a_tsrc_rdy_n, a_tdst_rdy_n;
  logic        b_cyc_n, b_tsof_n, b_teof_n, b_trem_n, b_tsrc_rdy_n, b_tdst_rdy_n;
  logic [63:0] a_td, b_td, trn_td;
  logic        trn_cyc_n, trn_tsof_n, trn_teof_n, trn_trem_n, trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n, trn_terr_drop_n;
  logic [5:0]  trn_tbuf_av;
  logic [15:0] stat_pkt_a, stat_pkt_b, stat_drop;
  logic        err_abort, err_timeout;

  int total = 0;
  int bad   = 0;

  always #5 trn_clk = ~trn_clk;

  hm_tx_arb #(.MIN_BUF_AV(6'd2), .TIMEOUT(16'd16)) dut (
    .trn_clk(trn_clk), .sys_rst(sys_rst),
    .a_cyc_n(a_cyc_n), .a_td(a_td), .a_tsof_n(a_tsof_n), .a_teof_n(a_teof_n),
    .a_trem_n(a_trem_n), .a_tsrc_rdy_n(a_tsrc_rdy_n), .a_tdst_rdy_n(a_tdst_rdy_n),
    .b_cyc_n(b_cyc_n), .b_td(b_td), .b_tsof_n(b_tsof_n), .b_teof_n(b_teof_n),
    .b_trem_n(b_trem_n), .b_tsrc_rdy_n(b_tsrc_rdy_n), .b_tdst_rdy_n(b_tdst_rdy_n),
    .trn_cyc_n(trn_cyc_n), .trn_td(trn_td), .trn_tsof_n(trn_tsof_n),
    .trn_teof_n(trn_teof_n), .trn_trem_n(trn_trem_n), .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
    .trn_tdst_rdy_n(trn_tdst_rdy_n), .trn_tbuf_av(trn_tbuf_av),
    .trn_terr_drop_n(trn_terr_drop_n),
    .stat_pkt_a(stat_pkt_a), .stat_pkt_b(stat_pkt_b), .stat_drop(stat_drop),
    .err_abort(err_abort), .err_timeout(err_timeout)
  );

  typedef struct {
    logic        a_cyc_n, a_src_n, a_sof_n, a_eof_n, a_rem_n;
    logic [63:0] a_td;
    logic        dst_n;
    logic [5:0]  tbuf;
    logic        e_cyc_n, e_src_n, e_sof_n, e_eof_n, e_rem_n;
    logic [63:0] e_td;
    logic        e_ardy_n, e_brdy_n;
    logic [15:0] e_pkt_a;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mkv(input logic c, s, so, eo, re, input logic [63:0] d,
                               input logic dn, input logic [5:0] tb,
                               input logic ec, es, eso, eeo, ere, input logic [63:0] ed,
                               input logic ear, ebr, input logic [15:0] ep);
    vec_t v;
    v.a_cyc_n = c; v.a_src_n = s; v.a_sof_n = so; v.a_eof_n = eo; v.a_rem_n = re;
    v.a_td = d; v.dst_n = dn; v.tbuf = tb;
    v.e_cyc_n = ec; v.e_src_n = es; v.e_sof_n = eso; v.e_eof_n = eeo; v.e_rem_n = ere;
    v.e_td = ed; v.e_ardy_n = ear; v.e_brdy_n = ebr; v.e_pkt_a = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic set_idle();
    a_cyc_n = 1; a_td = '0; a_tsof_n = 1; a_teof_n = 1; a_trem_n = 1; a_tsrc_rdy_n = 1;
    b_cyc_n = 1; b_td = '0; b_tsof_n = 1; b_teof_n = 1; b_trem_n = 1; b_tsrc_rdy_n = 1;
    trn_tdst_rdy_n = 0; trn_tbuf_av = 6'd8; trn_terr_drop_n = 1;
  endtask

  task automatic reset_dut();
    set_idle();
    sys_rst = 1;
    @(posedge trn_clk);
    @(posedge trn_clk);
    #1 sys_rst = 0;
  endtask

  task automatic req_a1(input logic [63:0] d);
    a_cyc_n = 0; a_tsrc_rdy_n = 0; a_tsof_n = 0; a_teof_n = 0; a_trem_n = 1; a_td = d;
  endtask

  task automatic req_b1(input logic [63:0] d);
    b_cyc_n = 0; b_tsrc_rdy_n = 0; b_tsof_n = 0; b_teof_n = 0; b_trem_n = 1; b_td = d;
  endtask

  task automatic drop_a();
    a_cyc_n = 1; a_tsrc_rdy_n = 1; a_tsof_n = 1; a_teof_n = 1; a_td = '0;
  endtask

  task automatic drop_b();
    b_cyc_n = 1; b_tsrc_rdy_n = 1; b_tsof_n = 1; b_teof_n = 1; b_td = '0;
  endtask

  // Randomized traffic sources and scoreboard state.
  bit          act[2];
  int          idx[2], len[2], gap[2], pkt_id[2], exp_pkts[2];
  logic [63:0] cur_td[2];
  logic        cur_rem[2];
  int          exp_drop, err_seen, open_port;
  bit          stop;

  function automatic logic [63:0] mk_td(input int p, input int pk, input int i);
    return {(p == 0) ? 8'hAA : 8'hBB, 8'(i), 16'(pk), 32'($urandom)};
  endfunction

  task automatic rnd_drive();
    logic c, s, so, eo, re;
    logic [63:0] d;
    for (int p = 0; p < 2; p++) begin
      if (!act[p]) begin
        if (gap[p] > 0) gap[p]--;
        else if (!stop) begin
          act[p] = 1; idx[p] = 0; len[p] = $urandom_range(1, 6); pkt_id[p]++;
          cur_td[p] = mk_td(p, pkt_id[p], 0);
          cur_rem[p] = 1'($urandom_range(0, 1));
        end
      end
      if (act[p]) begin
        c = 0; s = ($urandom_range(0, 9) == 0); d = cur_td[p];
        so = (idx[p] != 0); eo = (idx[p] != len[p] - 1); re = eo ? 1'b1 : cur_rem[p];
      end else begin
        c = 1; s = 1; d = '0; so = 1; eo = 1; re = 1;
      end
      if (p == 0) begin
        a_cyc_n = c; a_tsrc_rdy_n = s; a_td = d; a_tsof_n = so; a_teof_n = eo; a_trem_n = re;
      end else begin
        b_cyc_n = c; b_tsrc_rdy_n = s; b_td = d; b_tsof_n = so; b_teof_n = eo; b_trem_n = re;
      end
    end
    trn_tdst_rdy_n  = ($urandom_range(0, 9) == 0);
    trn_tbuf_av     = ($urandom_range(0, 6) == 0) ? 6'($urandom_range(0, 1)) : 6'($urandom_range(2, 63));
    trn_terr_drop_n = ($urandom_range(0, 19) != 0);
  endtask

  // Every beat a source hands over must appear once on the core side, unmerged and in order.
  task automatic rnd_observe();
    logic hs[2];
    logic trn_acc, ok;
    logic [66:0] got, want;
    int tp;
    hs[0]   = !a_cyc_n && !a_tsrc_rdy_n && !a_tdst_rdy_n;
    hs[1]   = !b_cyc_n && !b_tsrc_rdy_n && !b_tdst_rdy_n;
    trn_acc = !trn_cyc_n && !trn_tsrc_rdy_n && !trn_tdst_rdy_n;
    if (trn_acc || hs[0] || hs[1]) begin
      tp   = hs[1] ? 1 : 0;
      got  = {trn_td, trn_tsof_n, trn_teof_n, trn_trem_n};
      want = (tp == 1) ? {b_td, b_tsof_n, b_teof_n, b_trem_n} : {a_td, a_tsof_n, a_teof_n, a_trem_n};
      ok   = trn_acc && (hs[0] != hs[1]) && (got == want) && (open_port < 0 || open_port == tp);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL rnd_beat got=%0h acc=%0b want=%0h hs=%0b%0b open=%0d",
                 got, trn_acc, want, hs[0], hs[1], open_port);
      end
      if (trn_acc) open_port = trn_teof_n ? tp : -1;
    end
    for (int p = 0; p < 2; p++) begin
      if (hs[p]) begin
        if (idx[p] == len[p] - 1) begin
          act[p] = 0; gap[p] = $urandom_range(1, 4); exp_pkts[p]++;
        end else begin
          idx[p]++; cur_td[p] = mk_td(p, pkt_id[p], idx[p]);
        end
      end
    end
    if (!trn_terr_drop_n) exp_drop++;
    if (err_abort || err_timeout) err_seen++;
  endtask

  initial begin
    int stuck;
    set_idle();
    #3;
    chk("reset_outputs",
        {trn_cyc_n, trn_td, trn_tsof_n, trn_teof_n, trn_trem_n, trn_tsrc_rdy_n,
         a_tdst_rdy_n, b_tdst_rdy_n, stat_pkt_a, stat_pkt_b, stat_drop, err_abort, err_timeout},
        {1'b1, 64'h0, 4'hF, 2'b11, 48'h0, 2'b00});
    @(posedge trn_clk);
    #1 sys_rst = 0;

    // A alone: buffer gating, 3-beat packet with a 5-cycle core stall.
    vecs[0]  = mkv(0,0,0,1,1,64'hA0,0,6'd1, 1,1,1,1,1,64'h0, 1,1,16'd0);
    vecs[1]  = mkv(0,0,0,1,1,64'hA0,0,6'd1, 1,1,1,1,1,64'h0, 1,1,16'd0);
    vecs[2]  = mkv(0,0,0,1,1,64'hA0,0,6'd2, 1,1,1,1,1,64'h0, 1,1,16'd0);
    vecs[3]  = mkv(0,0,0,1,1,64'hA0,0,6'd2, 0,0,0,1,1,64'hA0, 0,1,16'd0);
    for (int i = 4; i < 9; i++)
      vecs[i] = mkv(0,0,1,1,1,64'hA1,1,6'd2, 0,0,1,1,1,64'hA1, 1,1,16'd0);
    vecs[9]  = mkv(0,0,1,1,1,64'hA1,0,6'd2, 0,0,1,1,1,64'hA1, 0,1,16'd0);
    vecs[10] = mkv(0,0,1,0,0,64'hA2,0,6'd2, 0,0,1,0,0,64'hA2, 0,1,16'd0);
    vecs[11] = mkv(1,1,1,1,1,64'h0,0,6'd2,  1,1,1,1,1,64'h0, 0,1,16'd0);
    vecs[12] = mkv(1,1,1,1,1,64'h0,0,6'd2,  1,1,1,1,1,64'h0, 1,1,16'd1);
    for (int i = 0; i < 13; i++) begin
      a_cyc_n = vecs[i].a_cyc_n; a_tsrc_rdy_n = vecs[i].a_src_n; a_tsof_n = vecs[i].a_sof_n;
      a_teof_n = vecs[i].a_eof_n; a_trem_n = vecs[i].a_rem_n; a_td = vecs[i].a_td;
      trn_tdst_rdy_n = vecs[i].dst_n; trn_tbuf_av = vecs[i].tbuf;
      #4;
      chk($sformatf("vec%0d", i),
          {trn_cyc_n, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n, trn_td,
           a_tdst_rdy_n, b_tdst_rdy_n, stat_pkt_a},
          {vecs[i].e_cyc_n, vecs[i].e_src_n, vecs[i].e_sof_n, vecs[i].e_eof_n, vecs[i].e_rem_n,
           vecs[i].e_td, vecs[i].e_ardy_n, vecs[i].e_brdy_n, vecs[i].e_pkt_a});
      nxt();
    end

    // Tie after reset: A first, B two cycles after A releases.
    reset_dut();
    req_a1(64'h1A); req_b1(64'h1B);
    #4; chk("tie_idle", trn_cyc_n, 1'b1); nxt();
    #4; chk("tie_gnt_a", {a_tdst_rdy_n, b_tdst_rdy_n, trn_td}, {2'b01, 64'h1A}); nxt();
    drop_a(); #4; nxt();
    #4; chk("tie_bubble", trn_cyc_n, 1'b1); nxt();
    #4; chk("tie_gnt_b", {a_tdst_rdy_n, b_tdst_rdy_n, trn_td}, {2'b10, 64'h1B}); nxt();
    drop_b(); #4; nxt();
    #4; chk("tie_counts", {stat_pkt_a, stat_pkt_b}, {16'd1, 16'd1});
    nxt();
    req_a1(64'h2A); nxt(); nxt(); drop_a(); nxt(); nxt();
    req_a1(64'h3A); req_b1(64'h3B); nxt();
    #4; chk("tie2_gnt_b", {a_tdst_rdy_n, b_tdst_rdy_n, trn_td, stat_pkt_a}, {2'b10, 64'h3B, 16'd2});

    // B aborts before EOF; then a 3-cycle drop burst.
    reset_dut();
    b_cyc_n = 0; b_tsrc_rdy_n = 0; b_tsof_n = 0; b_teof_n = 1; b_td = 64'hB0;
    nxt(); nxt();
    drop_b(); #4; chk("abort_early", err_abort, 1'b0); nxt();
    #4; chk("abort_pulse", {err_abort, stat_pkt_b, trn_cyc_n}, {1'b1, 16'd0, 1'b1}); nxt();
    #4; chk("abort_clear", err_abort, 1'b0);
    nxt();
    trn_terr_drop_n = 0; nxt(); nxt(); nxt();
    trn_terr_drop_n = 1; #4; chk("drop_cnt", stat_drop, 16'd3);
    nxt();

    // Watchdog: A holds the frame open and never offers a beat.
    a_cyc_n = 0; a_tsrc_rdy_n = 1; a_td = 64'hDEAD; nxt();
    stuck = 0;
    for (int i = 1; i <= 16; i++) begin
      #4; if (trn_cyc_n !== 1'b0 || err_timeout !== 1'b0) stuck++;
      nxt();
    end
    chk("wdog_grant_hold", stuck, 0);
    #4; chk("wdog_fire", {trn_cyc_n, err_timeout}, 2'b11); nxt();
    #4; chk("wdog_blocked", {trn_cyc_n, err_timeout, a_tdst_rdy_n, stat_pkt_a}, {3'b101, 16'd0}); nxt();
    a_cyc_n = 1; nxt();
    a_cyc_n = 0; #4; chk("wdog_req_idle", trn_cyc_n, 1'b1); nxt();
    #4; chk("wdog_regrant", {trn_cyc_n, trn_td}, {1'b0, 64'hDEAD});

    // Reset in the middle of a grant acts without a clock edge.
    sys_rst = 1; #1;
    chk("rst_mid", {trn_cyc_n, trn_td, trn_tsrc_rdy_n, a_tdst_rdy_n, stat_drop, err_timeout},
        {1'b1, 64'h0, 2'b11, 16'd0, 1'b0});
    reset_dut();

    // Randomized traffic against the packet-level scoreboard.
    open_port = -1; stop = 0; exp_drop = 0; err_seen = 0;
    for (int i = 0; i < 3000; i++) begin
      rnd_drive(); #4; rnd_observe(); nxt();
    end
    stop = 1;
    for (int i = 0; i < 400 && (act[0] || act[1]); i++) begin
      rnd_drive(); #4; rnd_observe(); nxt();
    end
    chk("rnd_drain", {act[0], act[1]}, 2'b00);
    for (int i = 0; i < 3; i++) begin
      set_idle(); #4; rnd_observe(); nxt();
    end
    #4;
    chk("rnd_pkt_a", stat_pkt_a, 16'(exp_pkts[0]));
    chk("rnd_pkt_b", stat_pkt_b, 16'(exp_pkts[1]));
    chk("rnd_drop", stat_drop, 16'(exp_drop));
    chk("rnd_err", err_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hm_tx_arb.md
Name: hm_tx_arb

Overview:
Two-port TRN transmit arbiter between the TLP sources and the PCIe core TX interface (trn_t*).
- Port A: expansion-ROM read completer.
- Port B: a second TLP source (DMA/message engine).
- Grants whole packets, never interleaves beats, round-robins on contention, gates grants on TX buffer availability.
- Keeps per-port packet counters, a TX drop counter, and a stuck-grant watchdog.

Parameters:
MIN_BUF_AV, 6'd2, minimum trn_tbuf_av required before any grant
TIMEOUT, 16'd4096, cycles a grant may sit with no accepted beat before forced release

Ports:
trn_clk  in  1  TRN clock
sys_rst  in  1  asynchronous active-high reset
a_cyc_n  in  1  port A packet request/frame, active low
a_td  in  64  port A data
a_tsof_n  in  1  port A start of frame
a_teof_n  in  1  port A end of frame
a_trem_n  in  1  port A remainder (0 = lower DW only valid on EOF)
a_tsrc_rdy_n  in  1  port A beat valid
a_tdst_rdy_n  out  1  port A ready
b_cyc_n, b_td, b_tsof_n, b_teof_n, b_trem_n, b_tsrc_rdy_n  in  1/64/1/1/1/1  port B, same meaning
b_tdst_rdy_n  out  1  port B ready
trn_cyc_n  out  1  to core
trn_td  out  64  to core
trn_tsof_n, trn_teof_n, trn_trem_n, trn_tsrc_rdy_n  out  1 each  to core
trn_tdst_rdy_n  in  1  core ready
trn_tbuf_av  in  6  core TX buffers available
trn_terr_drop_n  in  1  core dropped a TLP, active low
stat_pkt_a  out  16  packets completed on A
stat_pkt_b  out  16  packets completed on B
stat_drop  out  16  drop events
err_abort  out  1  one-cycle pulse: grant released without EOF
err_timeout  out  1  one-cycle pulse: watchdog fired

Behaviour:
- Async reset: state IDLE, last_grant=B (so A wins the first tie), counters 0, err pulses 0, eof_seen 0, watchdog 0.
- Async reset outputs: trn_cyc_n/tsof_n/teof_n/trem_n/tsrc_rdy_n=1, trn_td=0, a/b_tdst_rdy_n=1.
- States: IDLE, GNT_A, GNT_B. State is registered; the data path is a combinational mux selected by state.

IDLE:
- trn_* outputs and both tdst_rdy_n sit at the reset values.
- Request = x_cyc_n==0. Grant only when trn_tbuf_av >= MIN_BUF_AV.
- One requester: go to its GNT state next cycle.
- Both requesting: grant the port != last_grant.
- last_grant updates on entry to the GNT state.

GNT_X:
- trn_cyc_n/td/tsof_n/teof_n/trem_n/tsrc_rdy_n = X's inputs.
- x_tdst_rdy_n = trn_tdst_rdy_n; the other port's tdst_rdy_n = 1.
- Accepted beat: x_cyc_n=0, x_tsrc_rdy_n=0, trn_tdst_rdy_n=0.
- Accepted beat with x_teof_n=0 sets eof_seen.
- Release when x_cyc_n=1, returning to IDLE next cycle.
  - If eof_seen: stat_pkt_X += 1 (16-bit wrap).
  - Else: pulse err_abort and do not count.
  - Clear eof_seen.
- Watchdog: counts cycles in GNT_X with no accepted beat; reset on every accepted beat and on IDLE.
- At watchdog == TIMEOUT-1: force IDLE, pulse err_timeout, no packet count. The port must drop cyc_n before it is re-granted; the IDLE request check still applies.
- Minimum one IDLE bubble between packets, so back-to-back grant latency is 2 cycles after release.
- stat_drop += 1 (wrap) on every cycle trn_terr_drop_n=0, in any state.
- Request withdrawn in IDLE before grant: no grant, no error.
- A tsof_n during a grant is passed through unchecked.
- Reset mid-packet: immediate IDLE; the downstream frame is truncated; counters clear.

Decomposition:
- hm.vh holds the state encodings `HM_ARB_STATE_IDLE/GNT_A/GNT_B`, alongside the existing `HM_MR_STATE_*`.
- Optional sub-module hm_tx_arb_wdog (counter + fire pulse), parameterised by TIMEOUT.
- The TX mux stays inline.

Test Plan:
- A alone, 3-beat packet (SOF beat 0, EOF beat 2, trem_n=0), trn_tdst_rdy_n=0 → trn_td equals A data one beat per cycle, stat_pkt_a=1, b_tdst_rdy_n=1 throughout.
- A and B request in the same cycle after reset → A granted first, B granted 2 cycles after A drops cyc_n; stat_pkt_a=1, stat_pkt_b=1. A second tie → B first.
- trn_tbuf_av=1 with A requesting → stays IDLE. Set trn_tbuf_av=2 → GNT_A next cycle.
- trn_tdst_rdy_n=1 for 5 cycles mid-packet → a_tdst_rdy_n=1 and no beat counted; packet completes once ready returns.
- Parameter override TIMEOUT=16, A holds cyc_n=0 with tsrc_rdy_n=1 → err_timeout pulse on cycle 16 of the grant, IDLE, stat_pkt_a unchanged.
- B drops cyc_n before EOF → err_abort pulse. trn_terr_drop_n low 3 cycles → stat_drop=3. Assert sys_rst mid-packet → all outputs at reset values without a clock edge.
